lcd_timing_controller: RTL and testbench
========================================

Name: lcd_timing_controller

Overview:
- Drives a 480x272 parallel RGB565 LCD panel: DE, HSYNC, VSYNC and 16-bit colour, with counter-based raster timing.
- Pixels come from a 17-bit dual-clock FIFO (read side on this block's clock), filled upstream by the memory video controller.
- Word format: bit16=1 is the frame-start marker (bits 15:0 ignored). bit16=0 is a pixel: R=[15:11], G=[10:5], B=[4:0].
- Keeps the panel frame-aligned with the stream using the markers.

Parameters:
- LCD_SCREEN_WIDTH, 480, active pixels per line
- LCD_SCREEN_HEIGHT, 272, active lines per frame
- H_SYNC, 4, HSYNC pulse width in clocks
- H_BACK, 43, horizontal back porch
- H_FRONT, 8, horizontal front porch
- V_SYNC, 4, VSYNC pulse width in lines
- V_BACK, 12, vertical back porch
- V_FRONT, 8, vertical front porch

Ports:
- clk  in  1  pixel clock (screen clock)
- reset  in  1  asynchronous, active-high reset
- queue_data_in  in  17  FIFO Q
- queue_empty  in  1  FIFO empty flag
- queue_rd_en  out  1  FIFO read enable
- queue_clk  out  1  FIFO read clock; equals clk
- LCD_DE  out  1  data enable, high during active pixels
- LCD_HSYNC  out  1  horizontal sync, active low
- LCD_VSYNC  out  1  vertical sync, active low
- LCD_B  out  5  blue
- LCD_G  out  6  green
- LCD_R  out  5  red

Behaviour:
- Reset: counters=0, state=SEEK, queue_rd_en=0, LCD_DE=0, LCD_HSYNC=1, LCD_VSYNC=1, RGB=0.
- h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_SYNC+H_BACK+WIDTH+H_FRONT (535).
- v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, where V_TOTAL=V_SYNC+V_BACK+HEIGHT+V_FRONT (296).
- Raw decode:
  - hsync low while h_cnt<H_SYNC.
  - vsync low while v_cnt<V_SYNC.
  - active when h_cnt in [H_SYNC+H_BACK, +WIDTH) and v_cnt in [V_SYNC+V_BACK, +HEIGHT).
- FIFO read latency: Q is valid the cycle after queue_rd_en=1 with queue_empty=0. queue_rd_en is never asserted while queue_empty=1.
- Output pipeline: LCD_DE/HSYNC/VSYNC are the raw decode delayed exactly 2 clocks. RGB is registered from Q in the same cycle, so colour and DE stay aligned.
- State STREAM:
  - Assert rd_en on every active counter position.
  - Pixel word: RGB = its fields.
  - FIFO empty at an active position: that pixel is black (0), no read, counters keep running (underrun is not re-timed).
  - Marker read at an active position: that pixel is black, and the state goes to ALIGNED (marker consumed).
  - At counter frame start (h=0, v=0): go to SEEK.
- State SEEK:
  - Assert rd_en at most every other cycle (read, inspect, read...) when not empty. This guarantees no word after a marker is consumed.
  - Pixel words are discarded and the displayed pixels are black.
  - Marker seen while v_cnt < V_SYNC+V_BACK (still in vertical blanking): go to STREAM for this frame.
  - Marker seen later: go to ALIGNED.
- State ALIGNED: no reads, black output. At counter frame start go to STREAM, because the marker was already consumed.
- Marker and counter frame start on the same cycle in SEEK: counts as blanking, so go to STREAM.
- Reset mid-frame: everything returns to the reset values immediately (asynchronous).

Decomposition:
- Shared package holds:
  - the marker bit index (16) and word width (17);
  - RGB565 field slices;
  - the state encoding (SEEK, ALIGNED, STREAM);
  - default panel timing constants.
- One natural sub-module: lcd_raster_counter. It holds h/v counters and raw sync/active decode, and outputs active, hsync, vsync and in_vblank.

Test Plan:
- Reset, then run 2 frames with FIFO empty -> HSYNC low 4 clocks every 535; VSYNC low 4 lines every 296 lines; DE high 480 clocks per line on 272 lines; RGB=0; rd_en never 1.
- Marker 17'h10000, then 480x272 pixels of 17'h0F800, all preloaded before the frame's active region -> that frame shows R=31, G=0, B=0 on every DE pixel; exactly 130561 reads; at the next frame start the state is SEEK.
- Pixels 17'h00123, 17'h00456 before the marker, then 17'h007E0 -> first two words discarded; displayed pixels G=63; first DE pixel is green.
- Marker arriving mid-active-area -> current frame black, state ALIGNED. Next frame streams without a read during blanking, and its first pixel is the word after the marker.
- Queue empties after 100 pixels of line 0 -> pixels 100..479 are black with rd_en=0; the next available word shows at the next active position; DE timing unchanged.
- Assert reset mid-line -> all outputs are at reset values in the same cycle; after release, the first HSYNC starts at h_cnt=0.

Source files
------------

// File: rtl/lcd_timing_controller_pkg.sv
// Shared definitions for the RGB565 LCD timing controller: FIFO word layout,
// colour field positions, controller states and default panel timing.
package lcd_timing_controller_pkg;

  localparam int WORD_W     = 17;
  localparam int MARKER_BIT = 16;
  localparam int PIX_W      = 16;

  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  localparam int DEF_WIDTH   = 480;
  localparam int DEF_HEIGHT  = 272;
  localparam int DEF_H_SYNC  = 4;
  localparam int DEF_H_BACK  = 43;
  localparam int DEF_H_FRONT = 8;
  localparam int DEF_V_SYNC  = 4;
  localparam int DEF_V_BACK  = 12;
  localparam int DEF_V_FRONT = 8;

  typedef enum logic [1:0] {
    ST_SEEK    = 2'd0,
    ST_ALIGNED = 2'd1,
    ST_STREAM  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t unpack_rgb(input logic [PIX_W-1:0] w);
    rgb565_t c;
    c.r = w[R_HI:R_LO];
    c.g = w[G_HI:G_LO];
    c.b = w[B_HI:B_LO];
    return c;
  endfunction

endpackage

// File: rtl/lcd_timing_controller_raster.sv
// Free-running raster counters with the raw (undelayed) sync/active decode.
module lcd_raster_counter
  import lcd_timing_controller_pkg::*;
#(
  parameter int LCD_SCREEN_WIDTH  = DEF_WIDTH,
  parameter int LCD_SCREEN_HEIGHT = DEF_HEIGHT,
  parameter int H_SYNC            = DEF_H_SYNC,
  parameter int H_BACK            = DEF_H_BACK,
  parameter int H_FRONT           = DEF_H_FRONT,
  parameter int V_SYNC            = DEF_V_SYNC,
  parameter int V_BACK            = DEF_V_BACK,
  parameter int V_FRONT           = DEF_V_FRONT
) (
  input  logic clk,
  input  logic reset,
  output logic active,
  output logic hsync,
  output logic vsync,
  output logic in_vblank,
  output logic frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + LCD_SCREEN_WIDTH + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + LCD_SCREEN_HEIGHT + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  // Horizontal counter wraps each line; vertical counter steps on that wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign hsync       = ~(h_cnt < HW'(H_SYNC));
  assign vsync       = ~(v_cnt < VW'(V_SYNC));
  assign in_vblank   = v_cnt < VW'(V_SYNC + V_BACK);
  assign frame_start = (h_cnt == '0) && (v_cnt == '0);
  assign active      = (h_cnt >= HW'(H_SYNC + H_BACK)) &&
                       (h_cnt <  HW'(H_SYNC + H_BACK + LCD_SCREEN_WIDTH)) &&
                       (v_cnt >= VW'(V_SYNC + V_BACK)) &&
                       (v_cnt <  VW'(V_SYNC + V_BACK + LCD_SCREEN_HEIGHT));

endmodule

// File: rtl/lcd_timing_controller.sv
// RGB565 LCD timing controller: raster timing plus FIFO pixel streaming that
// stays frame-aligned using frame-start marker words.
module lcd_timing_controller
  import lcd_timing_controller_pkg::*;
#(
  parameter int LCD_SCREEN_WIDTH  = DEF_WIDTH,
  parameter int LCD_SCREEN_HEIGHT = DEF_HEIGHT,
  parameter int H_SYNC            = DEF_H_SYNC,
  parameter int H_BACK            = DEF_H_BACK,
  parameter int H_FRONT           = DEF_H_FRONT,
  parameter int V_SYNC            = DEF_V_SYNC,
  parameter int V_BACK            = DEF_V_BACK,
  parameter int V_FRONT           = DEF_V_FRONT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] queue_data_in,
  input  logic              queue_empty,
  output logic              queue_rd_en,
  output logic              queue_clk,
  output logic              LCD_DE,
  output logic              LCD_HSYNC,
  output logic              LCD_VSYNC,
  output logic [4:0]        LCD_B,
  output logic [5:0]        LCD_G,
  output logic [4:0]        LCD_R
);

  logic    raw_active, raw_hsync, raw_vsync, in_vblank, frame_start;
  state_t  state, state_nxt;
  logic    rd_req;
  logic    vld_p0, strm_p0, de_p0, hs_p0, vs_p0;
  logic    marker_p1;
  rgb565_t pix_p1;

  lcd_raster_counter #(
    .LCD_SCREEN_WIDTH (LCD_SCREEN_WIDTH),
    .LCD_SCREEN_HEIGHT(LCD_SCREEN_HEIGHT),
    .H_SYNC           (H_SYNC),
    .H_BACK           (H_BACK),
    .H_FRONT          (H_FRONT),
    .V_SYNC           (V_SYNC),
    .V_BACK           (V_BACK),
    .V_FRONT          (V_FRONT)
  ) u_raster (
    .clk        (clk),
    .reset      (reset),
    .active     (raw_active),
    .hsync      (raw_hsync),
    .vsync      (raw_vsync),
    .in_vblank  (in_vblank),
    .frame_start(frame_start)
  );

  assign queue_clk = clk;
  // Reset forces the read strobe low immediately, independent of state.
  assign queue_rd_en = rd_req & ~reset;
  assign marker_p1   = vld_p0 & queue_data_in[MARKER_BIT];
  // Only words fetched while streaming reach the panel; everything else is black.
  assign pix_p1 = (strm_p0 && !queue_data_in[MARKER_BIT]) ?
                  unpack_rgb(queue_data_in[PIX_W-1:0]) : '0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SEEK;
    else       state <= state_nxt;
  end

  // Alignment FSM: read policy per state and marker/frame-start transitions.
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    case (state)
      ST_STREAM: begin
        rd_req = raw_active & ~queue_empty;
        if (frame_start)    state_nxt = ST_SEEK;
        else if (marker_p1) state_nxt = ST_ALIGNED;
      end
      ST_SEEK: begin
        // Skip the cycle in which the previous word is inspected so nothing
        // beyond a marker is ever consumed.
        rd_req = ~queue_empty & ~vld_p0;
        if (marker_p1) state_nxt = in_vblank ? ST_STREAM : ST_ALIGNED;
      end
      ST_ALIGNED: begin
        if (frame_start) state_nxt = ST_STREAM;
      end
      default: state_nxt = ST_SEEK;
    endcase
  end

  // Stage p0: raw decode and read-issued flags; FIFO Q is valid next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      strm_p0 <= 1'b0;
      de_p0   <= 1'b0;
      hs_p0   <= 1'b1;
      vs_p0   <= 1'b1;
    end else begin
      vld_p0  <= rd_req;
      strm_p0 <= rd_req & (state == ST_STREAM);
      de_p0   <= raw_active;
      hs_p0   <= raw_hsync;
      vs_p0   <= raw_vsync;
    end
  end

  // Stage p1: panel outputs, colour registered from Q alongside delayed timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      LCD_DE    <= 1'b0;
      LCD_HSYNC <= 1'b1;
      LCD_VSYNC <= 1'b1;
      LCD_R     <= '0;
      LCD_G     <= '0;
      LCD_B     <= '0;
    end else begin
      LCD_DE    <= de_p0;
      LCD_HSYNC <= hs_p0;
      LCD_VSYNC <= vs_p0;
      LCD_R     <= pix_p1.r;
      LCD_G     <= pix_p1.g;
      LCD_B     <= pix_p1.b;
    end
  end

endmodule

// File: tb/tb_lcd_timing_controller.sv
// Scoreboard bench for lcd_timing_controller using a reduced panel geometry.
module tb_lcd_timing_controller;

  localparam int W  = 12;
  localparam int H  = 6;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int HF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VF = 2;
  localparam int HT    = HS + HB + W + HF;
  localparam int VT    = VS + VB + H + VF;
  localparam int FRAME = HT * VT;
  localparam int N     = W * H;
  localparam int A0    = (VS + VB) * HT + HS + HB;

  typedef struct {
    int cyc;
    int reads;
    bit empty_chk;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] q_reg = '0;
  logic        fifo_empty = 1'b1;
  logic        queue_rd_en, queue_clk;
  logic        LCD_DE, LCD_HSYNC, LCD_VSYNC;
  logic [4:0]  LCD_R, LCD_B;
  logic [5:0]  LCD_G;

  logic [16:0] fifo[$];
  logic [15:0] exp_q[$];
  req_t        req_q[$];
  int          cyc = 0;
  int          rd_count = 0;
  int          rd_base = 0;
  bit          sb_on = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  lcd_timing_controller #(
    .LCD_SCREEN_WIDTH (W),
    .LCD_SCREEN_HEIGHT(H),
    .H_SYNC           (HS),
    .H_BACK           (HB),
    .H_FRONT          (HF),
    .V_SYNC           (VS),
    .V_BACK           (VB),
    .V_FRONT          (VF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .queue_data_in(q_reg),
    .queue_empty  (fifo_empty),
    .queue_rd_en  (queue_rd_en),
    .queue_clk    (queue_clk),
    .LCD_DE       (LCD_DE),
    .LCD_HSYNC    (LCD_HSYNC),
    .LCD_VSYNC    (LCD_VSYNC),
    .LCD_B        (LCD_B),
    .LCD_G        (LCD_G),
    .LCD_R        (LCD_R)
  );

  always #5 clk = ~clk;

  // Show-ahead-free FIFO model: Q updates the cycle after a granted read.
  always @(posedge clk) begin
    if (queue_rd_en && fifo.size() > 0) begin
      q_reg    <= fifo.pop_front();
      rd_count <= rd_count + 1;
    end
    fifo_empty <= (fifo.size() == 0);
  end

  // Clock count since reset release, i.e. the raster position of the counters.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: reset values, timing decoded from raster arithmetic, pixel
  // scoreboard on every DE pixel, and scheduled read-count checkpoints.
  always @(negedge clk) begin : mon
    int p, h, v;
    logic [2:0]  e3;
    logic [15:0] e;
    req_t r;
    if (reset) begin
      check("reset_outputs",
            32'({LCD_DE, LCD_HSYNC, LCD_VSYNC, LCD_R, LCD_G, LCD_B, queue_rd_en}),
            32'({1'b0, 1'b1, 1'b1, 16'h0000, 1'b0}));
    end else begin
      if (cyc < 2) e3 = 3'b011;
      else begin
        p  = cyc - 2;
        h  = p % HT;
        v  = (p / HT) % VT;
        e3 = {(h >= HS + HB) && (h < HS + HB + W) && (v >= VS + VB) && (v < VS + VB + H),
              !(h < HS), !(v < VS)};
      end
      check("de_hsync_vsync", 32'({LCD_DE, LCD_HSYNC, LCD_VSYNC}), 32'(e3));
      check("rd_while_empty", 32'(queue_rd_en & fifo_empty), 32'd0);
      if (sb_on && LCD_DE) begin
        check("scoreboard_has_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pixel_rgb", 32'({LCD_R, LCD_G, LCD_B}), 32'(e));
        end
      end
      if (req_q.size() != 0 && req_q[0].cyc == cyc) begin
        r = req_q.pop_front();
        check("read_count", 32'(rd_count - rd_base), 32'(r.reads));
        if (r.empty_chk) check("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic wait_neg(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        $display("FAIL wait_timeout: cyc %0d target %0d", cyc, k);
        $fatal(1, "bench wait bound expired");
      end
    end while (cyc != k);
  endtask

  task automatic start_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb_on = 1'b0;
    exp_q.delete();
    req_q.delete();
    fifo.delete();
  endtask

  task automatic release_reset();
    @(negedge clk);
    @(posedge clk);
    #2;
    rd_base = rd_count;
    reset   = 1'b0;
  endtask

  task automatic add_req(input int c, input int r, input bit e);
    req_t q;
    q.cyc = c;
    q.reads = r;
    q.empty_chk = e;
    req_q.push_back(q);
  endtask

  function automatic logic [16:0] rnd_pix();
    return {1'b0, 16'($urandom)};
  endfunction

  function automatic logic [16:0] rnd_marker();
    return {1'b1, 16'($urandom)};
  endfunction

  initial begin
    logic [16:0] w;
    logic [16:0] later[$];
    int j_cnt, k_cnt, vm, hm, cm, pc, qc;

    // Empty FIFO for two frames: black, no reads, timing checked by monitor.
    start_reset();
    for (int i = 0; i < 2 * N; i++) exp_q.push_back(16'h0000);
    add_req(2 * FRAME + 2, 0, 1'b1);
    sb_on = 1'b1;
    release_reset();
    wait_neg(2 * FRAME + 3);

    // Optional junk, marker and a full frame preloaded; next frame seeks.
    for (int it = 0; it < 3; it++) begin
      start_reset();
      j_cnt = (it == 0) ? 0 : (it == 1) ? 2 : int'($urandom_range(1, 3));
      for (int j = 0; j < j_cnt; j++) begin
        if (it == 1) w = (j == 0) ? 17'h00123 : 17'h00456;
        else         w = rnd_pix();
        fifo.push_back(w);
      end
      fifo.push_back(rnd_marker());
      for (int i = 0; i < N; i++) begin
        if (it == 0)      w = 17'h0F800;
        else if (it == 1) w = 17'h007E0;
        else              w = rnd_pix();
        fifo.push_back(w);
        exp_q.push_back(w[15:0]);
      end
      for (int i = 0; i < N; i++) exp_q.push_back(16'h0000);
      k_cnt = $urandom_range(1, 6);
      add_req(FRAME, j_cnt + 1 + N, 1'b0);
      add_req(2 * FRAME + 2, j_cnt + 1 + N + k_cnt, 1'b1);
      sb_on = 1'b1;
      release_reset();
      wait_neg(FRAME + 3);
      for (int k = 0; k < k_cnt; k++) fifo.push_back(rnd_pix());
      wait_neg(2 * FRAME + 3);
    end

    // Marker arrives mid-active: frame black, next frame streams after it.
    for (int it = 0; it < 3; it++) begin
      start_reset();
      for (int i = 0; i < N; i++) exp_q.push_back(16'h0000);
      later.delete();
      for (int i = 0; i < N; i++) begin
        w = rnd_pix();
        later.push_back(w);
        exp_q.push_back(w[15:0]);
      end
      vm = $urandom_range(VS + VB, VS + VB + H - 2);
      hm = $urandom_range(0, HT - 1);
      cm = vm * HT + hm;
      add_req(FRAME + A0, 1, 1'b0);
      add_req(2 * FRAME + 2, 1 + N, 1'b1);
      sb_on = 1'b1;
      release_reset();
      wait_neg(cm);
      fifo.push_back(rnd_marker());
      foreach (later[i]) fifo.push_back(later[i]);
      wait_neg(2 * FRAME + 3);
    end

    // Underrun on line 0: gap is black, refill shows at next active slot.
    for (int it = 0; it < 3; it++) begin
      start_reset();
      pc = $urandom_range(1, W - 2);
      qc = $urandom_range(pc + 1, W - 1);
      fifo.push_back(rnd_marker());
      for (int j = 0; j < pc; j++) begin
        w = rnd_pix();
        fifo.push_back(w);
        exp_q.push_back(w[15:0]);
      end
      for (int j = pc; j < qc; j++) exp_q.push_back(16'h0000);
      later.delete();
      for (int j = qc; j < N; j++) begin
        w = rnd_pix();
        later.push_back(w);
        exp_q.push_back(w[15:0]);
      end
      add_req(FRAME + 2, 1 + pc + N - qc, 1'b1);
      sb_on = 1'b1;
      release_reset();
      wait_neg(A0 + qc - 1);
      foreach (later[i]) fifo.push_back(later[i]);
      wait_neg(FRAME + 3);
    end

    // Reset asserted mid-line with reads pending, then timing restarts.
    start_reset();
    release_reset();
    wait_neg(HT + 5);
    for (int k = 0; k < 60; k++) fifo.push_back(rnd_pix());
    wait_neg(2 * HT + int'($urandom_range(2, HT - 3)));
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    release_reset();
    wait_neg(3 * HT + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
